// File: rtl/tpu_mmio_pkg.sv
// rtl/tpu_mmio_pkg.sv - address map, FSM states and request record shared by tpu_mmio_ctrl
package tpu_mmio_pkg;

    localparam logic [15:0] ADDR_CTRL   = 16'h0040;
    localparam logic [15:0] ADDR_STATUS = 16'h0042;
    localparam logic [15:0] ADDR_STATS  = 16'h0044;
    localparam logic [7:0]  TPU_WIN_HI  = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP,
        S_RUN
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] wdata;
    } req_t;

    function automatic logic in_tpu_win(input logic [15:0] addr);
        return addr[15:8] == TPU_WIN_HI;
    endfunction

endpackage

// File: rtl/tpu_req_fifo.sv
// rtl/tpu_req_fifo.sv - DEPTH-entry request FIFO; pushes when full and pops when empty are ignored
module tpu_req_fifo
    import tpu_mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_mmio_ctrl.sv
// rtl/tpu_mmio_ctrl.sv - MMIO-to-TPU request sequencer with CSRs; STATS counters under TPU_MMIO_CTRL_STATS_EN
module tpu_mmio_ctrl
    import tpu_mmio_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        tpu_r_w,
    output logic        tpu_rd_en,
    output logic [15:0] tpu_addr,
    output logic [63:0] tpu_din,
    input  logic [63:0] tpu_dout,
    output logic        tpu_start,
    input  logic        tpu_done,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t      state;
    req_t        push_req;
    req_t        fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        strobe_err;
    logic        err;
    logic        done;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [8:0]  req_tid;
    logic [1:0]  req_ctrl;
    logic [1:0]  wait_cnt;
    logic [63:0] csr_val;
    logic [63:0] stats_val;

    // On a double strobe the write wins and the read is the one discarded
    assign push_req   = '{wr: mmio_wr_valid, addr: mmio_addr, tid: mmio_tid, wdata: mmio_wdata};
    assign fifo_push  = (mmio_wr_valid || mmio_rd_valid) && !fifo_full;
    assign fifo_pop   = (state == S_IDLE) && !fifo_empty;
    assign strobe_err = (mmio_wr_valid && mmio_rd_valid) ||
                        ((mmio_wr_valid || mmio_rd_valid) && fifo_full);

    tpu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        csr_val = '0;
        if (req_addr == ADDR_STATUS) begin
            csr_val = {61'b0, err, done, state == S_RUN};
        end else if (req_addr == ADDR_STATS) begin
            csr_val = stats_val;
        end
    end

`ifdef TPU_MMIO_CTRL_STATS_EN
    logic [31:0] drop_cnt;
    logic [31:0] acc_cnt;
    logic [1:0]  drop_inc;
    logic        acc_inc;

    assign drop_inc = {1'b0, mmio_wr_valid && mmio_rd_valid} +
                      {1'b0, (mmio_wr_valid || mmio_rd_valid) && fifo_full};
    assign acc_inc  = ((state == S_ISSUE) && req_wr && in_tpu_win(req_addr)) ||
                      ((state == S_WAIT_RD) && (wait_cnt == WAIT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            acc_cnt  <= '0;
        end else begin
            if (drop_cnt > (32'hFFFF_FFFF - 32'(drop_inc))) begin
                drop_cnt <= '1;
            end else begin
                drop_cnt <= drop_cnt + 32'(drop_inc);
            end
            if (acc_inc && (acc_cnt != '1)) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

    assign stats_val = {drop_cnt, acc_cnt};
`else
    assign stats_val = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            err       <= 1'b0;
            done      <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_tid   <= '0;
            req_ctrl  <= '0;
            wait_cnt  <= '0;
            tpu_r_w   <= 1'b0;
            tpu_rd_en <= 1'b0;
            tpu_addr  <= '0;
            tpu_din   <= '0;
            tpu_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            tpu_r_w   <= 1'b0;
            tpu_rd_en <= 1'b0;
            tpu_start <= 1'b0;
            rsp_valid <= 1'b0;
            if (strobe_err) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        req_wr   <= fifo_head.wr;
                        req_addr <= fifo_head.addr;
                        req_tid  <= fifo_head.tid;
                        req_ctrl <= fifo_head.wdata[1:0];
                        state    <= S_ISSUE;
                        // TPU strobes are registered here so they are high exactly during ISSUE
                        if (in_tpu_win(fifo_head.addr)) begin
                            tpu_addr <= fifo_head.addr;
                            if (fifo_head.wr) begin
                                tpu_r_w <= 1'b1;
                                tpu_din <= fifo_head.wdata;
                            end else begin
                                tpu_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_wr) begin
                        state <= S_IDLE;
                        if (req_addr == ADDR_CTRL) begin
                            if (req_ctrl[1] && !strobe_err) begin
                                err <= 1'b0;
                            end
                            if (req_ctrl[0]) begin
                                tpu_start <= 1'b1;
                                done      <= 1'b0;
                                state     <= S_RUN;
                            end
                        end
                    end else if (in_tpu_win(req_addr)) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT_RD;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_tid   <= req_tid;
                        rsp_data  <= csr_val;
                        state     <= S_RESP;
                    end
                end
                S_WAIT_RD: begin
                    // tpu_dout is captured on the edge into RESP so rsp_data is stable while rsp_valid is high
                    if (wait_cnt == WAIT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_tid   <= req_tid;
                        rsp_data  <= tpu_dout;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                S_RUN: begin
                    if (tpu_done) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_mmio_ctrl.sv
// tb/tb_tpu_mmio_ctrl.sv - self-checking bench for tpu_mmio_ctrl with a TPU memory model
module tb_tpu_mmio_ctrl;
    import tpu_mmio_pkg::*;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_wr_valid = 1'b0;
    logic        mmio_rd_valid = 1'b0;
    logic [15:0] mmio_addr = '0;
    logic [8:0]  mmio_tid = '0;
    logic [63:0] mmio_wdata = '0;
    logic        tpu_r_w;
    logic        tpu_rd_en;
    logic [15:0] tpu_addr;
    logic [63:0] tpu_din;
    logic [63:0] tpu_dout;
    logic        tpu_start;
    logic        tpu_done = 1'b0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    always #5 clk = ~clk;

    tpu_mmio_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .tpu_r_w       (tpu_r_w),
        .tpu_rd_en     (tpu_rd_en),
        .tpu_addr      (tpu_addr),
        .tpu_din       (tpu_din),
        .tpu_dout      (tpu_dout),
        .tpu_start     (tpu_start),
        .tpu_done      (tpu_done),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data)
    );

    // TPU device: memory with an RD_LAT-deep read pipeline
    logic [63:0] tpu_mem [256];
    logic [63:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (tpu_r_w) tpu_mem[tpu_addr[7:0]] <= tpu_din;
        rd_pipe[0] <= tpu_rd_en ? tpu_mem[tpu_addr[7:0]] : 64'h0BAD_0BAD_0BAD_0BAD;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign tpu_dout = rd_pipe[RD_LAT-1];

    typedef struct { logic [8:0] tid; logic [63:0] data; int at; } rsp_t;
    rsp_t        rsp_q[$];
    logic [79:0] wr_q[$];
    int cyc = 0, rd_en_cnt = 0, start_cnt = 0, both_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back('{rsp_tid, rsp_data, cyc});
        if (tpu_r_w) wr_q.push_back({tpu_addr, tpu_din});
        if (tpu_rd_en) rd_en_cnt++;
        if (tpu_start) start_cnt++;
        if (tpu_r_w && tpu_rd_en) both_cnt++;
    end

    // Reference model state
    logic [63:0] ref_mem [256];
    logic        m_err = 1'b0, m_done = 1'b0;
    int          m_drop = 0, m_acc = 0;
    int          n_checks = 0, n_pass = 0, n_fail = 0;

    function automatic logic [63:0] exp_status();
        return {61'b0, m_err, m_done, 1'b0};
    endfunction

    function automatic logic [63:0] exp_stats();
`ifdef TPU_MMIO_CTRL_STATS_EN
        return {32'(m_drop), 32'(m_acc)};
`else
        return 64'h0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [8:0] t, input logic [63:0] d, output int at);
        @(negedge clk);
        mmio_wr_valid = wr; mmio_rd_valid = rd;
        mmio_addr = a; mmio_tid = t; mmio_wdata = d;
        at = cyc;
        @(negedge clk);
        mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [8:0] t, input logic [63:0] d,
                              input int at, input int lat);
        rsp_t r;
        int   w = 0;
        while (rsp_q.size() == 0 && w < 200) begin @(posedge clk); w++; end
        if (rsp_q.size() == 0) begin
            check({tag, "_timeout"}, 64'(rsp_q.size()), 64'd1);
        end else begin
            r = rsp_q.pop_front();
            check({tag, "_tid"}, 64'(r.tid), 64'(t));
            check({tag, "_data"}, r.data, d);
            if (lat >= 0) check({tag, "_lat"}, 64'(r.at - at), 64'(lat));
        end
        @(negedge clk);
    endtask

    task automatic tpu_write(input string tag, input logic [15:0] a, input logic [63:0] d);
        int          at, w;
        logic [79:0] e;
        send(1'b1, 1'b0, a, 9'h0, d, at);
        ref_mem[a[7:0]] = d;
        m_acc++;
        w = 0;
        while (wr_q.size() == 0 && w < 50) begin @(negedge clk); w++; end
        check({tag, "_seen"}, 64'(wr_q.size()), 64'd1);
        if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            check({tag, "_addr"}, 64'(e[79:64]), 64'(a));
            check({tag, "_din"}, e[63:0], d);
        end
    endtask

    task automatic tpu_read(input string tag, input logic [15:0] a, input logic [8:0] t);
        int at;
        send(1'b0, 1'b1, a, t, 64'h0, at);
        expect_rsp(tag, t, ref_mem[a[7:0]], at, RD_LAT + 3);
        m_acc++;
    endtask

    task automatic csr_read(input string tag, input logic [15:0] a, input logic [8:0] t,
                            input logic [63:0] exp);
        int at;
        send(1'b0, 1'b1, a, t, 64'h0, at);
        expect_rsp(tag, t, exp, at, 3);
    endtask

    task automatic ctrl_write(input logic [63:0] v);
        int at;
        send(1'b1, 1'b0, ADDR_CTRL, 9'h0, v, at);
    endtask

    task automatic pulse_done();
        @(negedge clk); tpu_done = 1'b1;
        @(negedge clk); tpu_done = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [63:0] d;
        logic [8:0]  t;
        logic [15:0] ra[$];
        int          at_q[$];
        int          at, base;

        for (int i = 0; i < 256; i++) begin
            tpu_mem[i] = {48'h5EED_0000_0000, 8'h00, 8'(i)};
            ref_mem[i] = {48'h5EED_0000_0000, 8'h00, 8'(i)};
        end
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({rsp_valid, tpu_r_w, tpu_rd_en, tpu_start}), 64'd0);
        check("rst_tpu_addr", 64'(tpu_addr), 64'd0);
        check("rst_tpu_din", tpu_din, 64'd0);
        check("rst_rsp", {rsp_data[54:0], rsp_tid}, 64'd0);
        rst = 1'b0;
        csr_read("rst_status", ADDR_STATUS, 9'h001, exp_status());

        // Scenario 1
        tpu_write("s1_wr", 16'h0310, 64'hDEAD_BEEF);
        tpu_read("s1_rd", 16'h0310, 9'h05);

        for (int i = 0; i < 8; i++) begin
            a = 16'h0300 | 16'($urandom_range(0, 255));
            d = {$urandom, $urandom};
            t = 9'($urandom);
            tpu_write("rnd_wr", a, d);
            tpu_read("rnd_rd", a, t);
        end
        for (int i = 0; i < 4; i++) begin
            do a = 16'($urandom);
            while (a[15:8] == 8'h03 || a == ADDR_CTRL || a == ADDR_STATUS || a == ADDR_STATS);
            csr_read("unmapped", a, 9'($urandom), 64'h0);
        end

        pulse_done();
        csr_read("done_ignored", ADDR_STATUS, 9'h002, exp_status());

        // Scenario 2
        ctrl_write(64'h1);
        m_done = 1'b0;
        repeat (3) @(negedge clk);
        check("s2_start", 64'(start_cnt), 64'd1);
        base = rd_en_cnt;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0300 | 16'($urandom_range(0, 255));
            ra.push_back(a);
            send(1'b0, 1'b1, a, 9'(9'h10 + i), 64'h0, at);
        end
        repeat (20) @(negedge clk);
        check("s2_no_rd", 64'(rd_en_cnt), 64'(base));
        pulse_done();
        m_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ra.pop_front();
            expect_rsp("s2_rsp", 9'(9'h10 + i), ref_mem[a[7:0]], 0, -1);
            m_acc++;
        end
        check("s2_rd_cnt", 64'(rd_en_cnt), 64'(base + 3));
        csr_read("s2_status", ADDR_STATUS, 9'h003, exp_status());

        // Scenario 3
        ctrl_write(64'h1);
        m_done = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) begin
            a = 16'h0300 | 16'($urandom_range(0, 255));
            if (i < DEPTH) ra.push_back(a);
            else begin m_drop++; m_err = 1'b1; end
            send(1'b0, 1'b1, a, 9'(9'h20 + i), 64'h0, at);
        end
        repeat (5) @(negedge clk);
        pulse_done();
        m_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a = ra.pop_front();
            expect_rsp("s3_rsp", 9'(9'h20 + i), ref_mem[a[7:0]], 0, -1);
            m_acc++;
        end
        repeat (10) @(negedge clk);
        check("s3_no_extra", 64'(rsp_q.size()), 64'd0);
        csr_read("s3_status", ADDR_STATUS, 9'h004, exp_status());
        csr_read("s3_stats", ADDR_STATS, 9'h005, exp_stats());

        // Scenario 4
        csr_read("s4_unmapped", 16'h1234, 9'h1FF, 64'h0);

        // Scenario 5
        ctrl_write(64'h2);
        m_err = 1'b0;
        csr_read("s5_pre_status", ADDR_STATUS, 9'h006, exp_status());
        d = {$urandom, $urandom};
        send(1'b1, 1'b1, 16'h0320, 9'h007, d, at);
        ref_mem[8'h20] = d;
        m_acc++; m_drop++; m_err = 1'b1;
        base = 0;
        while (wr_q.size() == 0 && base < 50) begin @(negedge clk); base++; end
        check("s5_wr_seen", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() != 0) check("s5_wr", wr_q.pop_front(), {16'h0320, d});
        repeat (10) @(negedge clk);
        check("s5_no_rsp", 64'(rsp_q.size()), 64'd0);
        csr_read("s5_err_status", ADDR_STATUS, 9'h008, exp_status());
        csr_read("s5_stats", ADDR_STATS, 9'h009, exp_stats());
        tpu_read("s5_rdback", 16'h0320, 9'h00A);
        ctrl_write(64'h2);
        m_err = 1'b0;
        csr_read("s5_clr_status", ADDR_STATUS, 9'h00B, exp_status());

        // Scenario 6
        send(1'b0, 1'b1, 16'h0330, 9'h003, 64'h0, at);
        @(negedge clk);
        @(negedge clk);
        check("s6_phase", 64'(dut.state), 64'(S_WAIT_RD));
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_err = 1'b0; m_done = 1'b0; m_drop = 0; m_acc = 0;
        repeat (10) @(negedge clk);
        check("s6_no_rsp", 64'(rsp_q.size()), 64'd0);
        check("s6_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
        csr_read("s6_status", ADDR_STATUS, 9'h00C, exp_status());
        csr_read("s6_stats", ADDR_STATS, 9'h00D, exp_stats());

        check("one_strobe", 64'(both_cnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
